// File: rtl/pe_bus_pkg.sv
// Shared defaults and state type for the PE data-bus arbiter.
package pe_bus_pkg;
  localparam int NUM_PE_DFLT       = 8;
  localparam int BUS_ADDR_LEN_DFLT = 3;
  localparam int MAX_BURST_DFLT    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic [N-1:0]  eligible,
  input  logic [AW-1:0] ptr,
  output logic [AW-1:0] winner,
  output logic          any
);
  logic [AW-1:0] idx;

  // Scan from the far end back toward ptr so the closest candidate is written last.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = AW'((int'(ptr) + k) % N);
      if (eligible[idx]) winner = idx;
    end
    any = |eligible;
  end
endmodule

// File: rtl/pe_bus_arbiter.sv
// Shared data-bus arbiter: round-robin source selection with bounded bursts and
// destination back-pressure; every output is registered.
//   state   | meaning
//   ST_IDLE | no owner, bus quiet
//   ST_XFER | owner_q holds the bus, beat_q = beats granted so far (1..MAX_BURST)
module pe_bus_arbiter
  import pe_bus_pkg::*;
#(
  parameter int NUM_PE       = NUM_PE_DFLT,
  parameter int BUS_ADDR_LEN = BUS_ADDR_LEN_DFLT,
  parameter int MAX_BURST    = MAX_BURST_DFLT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PE-1:0]              req_valid,
  input  logic [NUM_PE*BUS_ADDR_LEN-1:0] req_addr,
  input  logic [NUM_PE-1:0]              dest_full,
  output logic [NUM_PE-1:0]              wr_grant,
  output logic [NUM_PE-1:0]              rd_enable,
  output logic [BUS_ADDR_LEN-1:0]        bus_addr,
  output logic                           bus_valid,
  output logic [15:0]                    grant_count
);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e              state_q, state_d;
  logic [BUS_ADDR_LEN-1:0] ptr_q, ptr_d;
  logic [BUS_ADDR_LEN-1:0] owner_q, owner_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [NUM_PE-1:0]       wr_grant_q, wr_grant_d;
  logic [NUM_PE-1:0]       rd_enable_q, rd_enable_d;
  logic [BUS_ADDR_LEN-1:0] bus_addr_q, bus_addr_d;
  logic                    bus_valid_q, bus_valid_d;
  logic [15:0]             grant_count_q, grant_count_d;

  logic [NUM_PE-1:0]       eligible;
  logic [BUS_ADDR_LEN-1:0] owner_inc, pick_ptr, pick_winner, sel, sel_addr;
  logic                    pick_any, keep, sel_valid;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PE; i++)
      eligible[i] = req_valid[i] & ~dest_full[req_addr[i*BUS_ADDR_LEN +: BUS_ADDR_LEN]];
  end

  // On release the search starts just past the outgoing owner, in the same edge.
  assign owner_inc = (int'(owner_q) == NUM_PE - 1) ? '0 : owner_q + 1'b1;
  assign pick_ptr  = (state_q == ST_XFER) ? owner_inc : ptr_q;

  rr_priority_picker #(
    .N  (NUM_PE),
    .AW (BUS_ADDR_LEN)
  ) u_picker (
    .eligible (eligible),
    .ptr      (pick_ptr),
    .winner   (pick_winner),
    .any      (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    beat_d    = beat_q;
    sel_valid = 1'b0;
    sel       = owner_q;
    keep      = (state_q == ST_XFER) && eligible[owner_q] && (beat_q < BW'(MAX_BURST));
    if (keep) begin
      sel_valid = 1'b1;
      beat_d    = beat_q + 1'b1;
    end else begin
      if (state_q == ST_XFER) ptr_d = owner_inc;
      if (pick_any) begin
        sel_valid = 1'b1;
        sel       = pick_winner;
        owner_d   = pick_winner;
        beat_d    = BW'(1);
        state_d   = ST_XFER;
      end else begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    end

    sel_addr      = req_addr[int'(sel)*BUS_ADDR_LEN +: BUS_ADDR_LEN];
    wr_grant_d    = '0;
    rd_enable_d   = '0;
    bus_addr_d    = '0;
    bus_valid_d   = 1'b0;
    grant_count_d = grant_count_q;
    if (sel_valid) begin
      wr_grant_d[sel]       = 1'b1;
      rd_enable_d[sel_addr] = 1'b1;
      bus_addr_d            = sel_addr;
      bus_valid_d           = 1'b1;
      grant_count_d         = grant_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      beat_q        <= '0;
      wr_grant_q    <= '0;
      rd_enable_q   <= '0;
      bus_addr_q    <= '0;
      bus_valid_q   <= 1'b0;
      grant_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      beat_q        <= beat_d;
      wr_grant_q    <= wr_grant_d;
      rd_enable_q   <= rd_enable_d;
      bus_addr_q    <= bus_addr_d;
      bus_valid_q   <= bus_valid_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign wr_grant    = wr_grant_q;
  assign rd_enable   = rd_enable_q;
  assign bus_addr    = bus_addr_q;
  assign bus_valid   = bus_valid_q;
  assign grant_count = grant_count_q;
endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Bench for pe_bus_arbiter: per-PE word queues feed a behavioural arbitration
// model; directed scenarios plus a randomized run are checked every cycle.
module tb_pe_bus_arbiter;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    dest_full = '0;
  logic [N-1:0]    wr_grant, rd_enable;
  logic [AW-1:0]   bus_addr;
  logic            bus_valid;
  logic [15:0]     grant_count;

  int n_checks = 0;
  int n_pass   = 0;

  int           q[N][$];
  logic [N-1:0] full_v = '0;
  int           m_owner = -1, m_beats = 0, m_ptr = 0, m_cnt = 0;
  logic [N-1:0] e_wr, e_rd;
  logic [AW-1:0] e_addr;
  logic         e_valid;

  always #5 clk = ~clk;

  pe_bus_arbiter #(.NUM_PE(N), .BUS_ADDR_LEN(AW), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .dest_full   (dest_full),
    .wr_grant    (wr_grant),
    .rd_enable   (rd_enable),
    .bus_addr    (bus_addr),
    .bus_valid   (bus_valid),
    .grant_count (grant_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() > 0);
      req_addr[i*AW +: AW] = '0;
      if (q[i].size() > 0) req_addr[i*AW +: AW] = AW'(q[i][0]);
    end
    dest_full = full_v;
  endtask

  // Decide what the edge about to happen should register; pop the granted word.
  task automatic model_step();
    bit elig[N];
    int w, d;
    w = -1;
    e_wr = '0; e_rd = '0; e_addr = '0; e_valid = 1'b0;
    if (reset) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_cnt = 0;
      return;
    end
    for (int i = 0; i < N; i++) elig[i] = (q[i].size() > 0) && !full_v[q[i][0]];
    if (m_owner >= 0 && elig[m_owner] && m_beats < MB) begin
      w = m_owner;
      m_beats++;
    end else begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
      for (int k = 0; k < N; k++)
        if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_owner = w;
      m_beats = (w >= 0) ? 1 : 0;
    end
    if (w >= 0) begin
      d = q[w].pop_front();
      e_wr    = N'(1) << w;
      e_rd    = N'(1) << d;
      e_addr  = AW'(d);
      e_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic cycle(input string tag);
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_wr"}, wr_grant, e_wr);
    check({tag, "_rd"}, rd_enable, e_rd);
    check({tag, "_addr"}, bus_addr, e_addr);
    check({tag, "_valid"}, bus_valid, e_valid);
    check({tag, "_cnt"}, grant_count, m_cnt);
    check({tag, "_onehot"}, ($countones(wr_grant) <= 1) && ($countones(rd_enable) <= 1), 1);
  endtask

  task automatic clear_and_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    full_v = '0;
    reset  = 1'b1;
    cycle("rst");
    check("rst_valid", bus_valid, 0);
    check("rst_cnt", grant_count, 0);
    reset = 1'b0;
  endtask

  initial begin
    // single beat: PE3 -> 5
    clear_and_reset();
    q[3].push_back(5);
    cycle("single");
    check("single_wr", wr_grant, 8'h08);
    check("single_rd", rd_enable, 8'h20);
    check("single_addr", bus_addr, 5);
    check("single_cnt", grant_count, 1);
    cycle("single_after");
    check("single_drop", bus_valid, 0);

    // self-addressed
    clear_and_reset();
    q[4].push_back(4);
    cycle("self");
    check("self_wr", wr_grant, 8'h10);
    check("self_rd", rd_enable, 8'h10);
    check("self_addr", bus_addr, 4);

    // everyone busy: four-beat bursts in index order, no gaps
    clear_and_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 5; j++) q[i].push_back((i + 1) % N);
    for (int k = 0; k < 33; k++) begin
      cycle("burst");
      check("burst_src", wr_grant, N'(1) << ((k / 4) % N));
      check("burst_dst", rd_enable, N'(1) << ((k / 4 + 1) % N));
      if (k == 31) check("burst_cnt32", grant_count, 32);
    end

    // blocked destination
    clear_and_reset();
    full_v = 8'h04;
    q[0].push_back(2);
    q[1].push_back(4);
    cycle("blk1");
    check("blk_first", wr_grant, 8'h02);
    cycle("blk2");
    check("blk_wait", wr_grant, 8'h00);
    full_v = 8'h00;
    cycle("blk3");
    check("blk_pe0", wr_grant, 8'h01);

    // destination fills mid-burst
    clear_and_reset();
    for (int j = 0; j < 6; j++) q[5].push_back(1);
    q[6].push_back(0);
    q[6].push_back(0);
    cycle("mid1");
    cycle("mid2");
    check("mid_beat2", wr_grant, 8'h20);
    full_v = 8'h02;
    cycle("mid3");
    check("mid_switch", wr_grant, 8'h40);
    check("mid_ptr", dut.ptr_q, 6);

    // reset in the middle of a burst
    clear_and_reset();
    for (int j = 0; j < 6; j++) q[2].push_back(3);
    cycle("rb1");
    cycle("rb2");
    q[0].push_back(1);
    q[7].push_back(5);
    cycle("rb3");
    check("rb_beat3", wr_grant, 8'h04);
    reset = 1'b1;
    cycle("rb_rst");
    check("rb_wr0", wr_grant, 0);
    check("rb_rd0", rd_enable, 0);
    check("rb_valid0", bus_valid, 0);
    reset = 1'b0;
    cycle("rb_post");
    check("rb_pe0", wr_grant, 8'h01);

    // randomized traffic, back-pressure and occasional reset
    clear_and_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 8 && $urandom_range(0, 2) == 0) q[i].push_back($urandom_range(0, N - 1));
      for (int i = 0; i < N; i++) full_v[i] = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
